button_conditioner: RTL

Front-end stage for the clock's four raw, active-low push-buttons (adjust, mode, up, down). It synchronises, debounces and edge-detects each button and produces clean single-cycle event pulses for the top-level mode/edit state machine in place of the raw pin levels. Up/down get hold-to-auto-repeat for fast value stepping. Adjust/mode get a one-shot long-press event.

---
 rtl/button_conditioner.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Front end for the four raw, active-low push-buttons of the clock. Each button
// is synchronised, debounced and edge-detected independently and turned into
// clean single-cycle event pulses for the mode/edit state machine.
// Auto-repeat buttons (REPEAT_MASK bit set) emit a step pulse on press and then
// repeatedly while held. The other buttons emit one long_press pulse per hold.
//
// Bit order on every vector: [3]=down, [2]=up, [1]=mode, [0]=adjust.
//
// Ports:
//   clk         system clock, the only clock of the block
//   rst_n       asynchronous active-low reset
//   btn_n       raw button pins, 0 = pressed, asynchronous to clk
//   held        debounced level, 1 = pressed
//   press       one-cycle pulse when a press is accepted
//   step        one-cycle pulse on press and on every repeat (masked bits only)
//   long_press  one-cycle pulse once per hold (unmasked bits only)
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES      = 1_000_000,
    parameter int unsigned REPEAT_DELAY_CYCLES  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD_CYCLES = 10_000_000,
    parameter logic [3:0]  REPEAT_MASK          = 4'b1100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_n,
    output logic [3:0] held,
    output logic [3:0] press,
    output logic [3:0] step,
    output logic [3:0] long_press
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                       REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int unsigned HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat,
        StLong
    } hold_state_e;

    // -------------------------------------------------------------------------
    // Two-flop synchroniser, reset to the released level
    // -------------------------------------------------------------------------
    logic [3:0] s1_q;
    logic [3:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= btn_n;
            s2_q <= s1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce: a level change is accepted only after s2 has differed from the
    // stable level for DEBOUNCE_CYCLES consecutive cycles.
    // -------------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt_q [4];
    logic [3:0]      stable_q;
    logic [3:0]      held_q;
    logic [3:0]      db_done;
    logic [3:0]      rise;
    logic [3:0]      fall;

    always_comb begin
        db_done = '0;
        for (int i = 0; i < 4; i++) begin
            db_done[i] = (s2_q[i] != stable_q[i]) && (db_cnt_q[i] == DB_LAST);
        end
        // rise/fall mark the edge on which held is about to change
        rise = db_done & ~s2_q;
        fall = db_done & s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
            stable_q <= '1;
            held_q   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s2_q[i] == stable_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_done[i]) begin
                    stable_q[i] <= s2_q[i];
                    held_q[i]   <= ~s2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-button hold FSM with registered event outputs. The FSM reacts to
    // rise/fall on the same edge that held changes, so press, the first step
    // and the held level all appear together, and a release cancels any event
    // that would otherwise coincide with it.
    // -------------------------------------------------------------------------
    hold_state_e       hold_state_q [4];
    logic [HOLD_W-1:0] hold_cnt_q   [4];
    logic [3:0]        press_q;
    logic [3:0]        step_q;
    logic [3:0]        long_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                hold_state_q[i] <= StIdle;
                hold_cnt_q[i]   <= '0;
            end
            press_q <= '0;
            step_q  <= '0;
            long_q  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                press_q[i] <= rise[i];
                step_q[i]  <= 1'b0;
                long_q[i]  <= 1'b0;

                if (fall[i]) begin
                    hold_state_q[i] <= StIdle;
                    hold_cnt_q[i]   <= '0;
                end else begin
                    unique case (hold_state_q[i])
                        StIdle: begin
                            if (rise[i]) begin
                                hold_state_q[i] <= StDelay;
                                hold_cnt_q[i]   <= '0;
                                step_q[i]       <= REPEAT_MASK[i];
                            end
                        end
                        StDelay: begin
                            if (hold_cnt_q[i] == DELAY_LAST) begin
                                hold_cnt_q[i] <= '0;
                                if (REPEAT_MASK[i]) begin
                                    step_q[i]       <= 1'b1;
                                    hold_state_q[i] <= StRepeat;
                                end else begin
                                    long_q[i]       <= 1'b1;
                                    hold_state_q[i] <= StLong;
                                end
                            end else begin
                                hold_cnt_q[i] <= hold_cnt_q[i] + 1'b1;
                            end
                        end
                        StRepeat: begin
                            if (hold_cnt_q[i] == PERIOD_LAST) begin
                                step_q[i]     <= 1'b1;
                                hold_cnt_q[i] <= '0;
                            end else begin
                                hold_cnt_q[i] <= hold_cnt_q[i] + 1'b1;
                            end
                        end
                        StLong: begin
                            // one-shot already fired; wait for release
                        end
                    endcase
                end
            end
        end
    end

    assign held       = held_q;
    assign press      = press_q;
    assign step       = step_q & REPEAT_MASK;
    assign long_press = long_q & ~REPEAT_MASK;

endmodule
